// File: rtl/sram_axi_slave.sv
// AXI4 SRAM slave, independent read/write burst engines; first R beat one cycle after AR, B one cycle after last W.
// R outputs hold while rready is low; wready is high throughout the data phase; B holds until bready.
module sram_axi_slave #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 16,
   parameter int ID_W   = 4,
   parameter int DEPTH  = 256
) (
   input  logic                i_aclk,
   input  logic                i_areset_n,
   input  logic [ID_W-1:0]     i_arid,
   input  logic [ADDR_W-1:0]   i_araddr,
   input  logic [7:0]          i_arlen,
   input  logic [1:0]          i_arburst,
   input  logic                i_arvalid,
   output logic                o_arready,
   output logic [ID_W-1:0]     o_rid,
   output logic [DATA_W-1:0]   o_rdata,
   output logic [1:0]          o_rresp,
   output logic                o_rlast,
   output logic                o_rvalid,
   input  logic                i_rready,
   input  logic [ID_W-1:0]     i_awid,
   input  logic [ADDR_W-1:0]   i_awaddr,
   input  logic [7:0]          i_awlen,
   input  logic [1:0]          i_awburst,
   input  logic                i_awvalid,
   output logic                o_awready,
   input  logic [DATA_W-1:0]   i_wdata,
   input  logic [DATA_W/8-1:0] i_wstrb,
   input  logic                i_wlast,
   input  logic                i_wvalid,
   output logic                o_wready,
   output logic [ID_W-1:0]     o_bid,
   output logic [1:0]          o_bresp,
   output logic                o_bvalid,
   input  logic                i_bready
);
   localparam int BYTES  = DATA_W / 8;
   localparam int LSB    = $clog2(BYTES);
   localparam int IDX_W  = ADDR_W - LSB;
   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        len;
      logic [1:0]        burst;
   } burst_t;

   logic [DATA_W-1:0] mem [DEPTH];

   function automatic logic out_of_range(input logic [IDX_W-1:0] idx);
      return {1'b0, idx} >= DEPTH_L;
   endfunction

   function automatic logic illegal_burst(input logic [7:0] len, input logic [1:0] burst);
      logic wrap_len_ok;
      wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      return (burst == 2'b11) || ((burst == BURST_WRAP) && !wrap_len_ok);
   endfunction

   // Illegal WRAP lengths and reserved burst type fall through to INCR addressing.
   function automatic logic [ADDR_W-1:0] next_addr(input burst_t b);
      logic [ADDR_W-1:0] incr;
      logic [ADDR_W-1:0] mask;
      incr = b.addr + ADDR_W'(BYTES);
      mask = (ADDR_W'(b.len) + ADDR_W'(1)) << LSB;
      mask = mask - ADDR_W'(1);
      if (b.burst == BURST_FIXED)
         return b.addr;
      if ((b.burst == BURST_WRAP) && !illegal_burst(b.len, b.burst))
         return (b.addr & ~mask) | (incr & mask);
      return incr;
   endfunction

   // ---------------- read engine ----------------
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   r_state_t          r_state, r_next;
   burst_t            rb, ar_req;
   logic [7:0]        r_cnt;
   logic              ar_fire, r_fire, rd_oor, rd_illegal;
   logic [ADDR_W-1:0] r_addr_nxt;
   logic [IDX_W-1:0]  rd_idx;

   assign ar_req     = '{addr: i_araddr, len: i_arlen, burst: i_arburst};
   assign ar_fire    = o_arready & i_arvalid;
   assign r_fire     = o_rvalid & i_rready;
   assign r_addr_nxt = next_addr(rb);
   assign rd_idx     = ar_fire ? i_araddr[ADDR_W-1:LSB] : r_addr_nxt[ADDR_W-1:LSB];
   assign rd_oor     = out_of_range(rd_idx);
   assign rd_illegal = ar_fire ? illegal_burst(i_arlen, i_arburst) : illegal_burst(rb.len, rb.burst);

   always_comb begin
      r_next    = r_state;
      o_arready = 1'b0;
      o_rvalid  = 1'b0;
      case (r_state)
         R_IDLE: begin
            o_arready = 1'b1;
            if (i_arvalid) r_next = R_DATA;
         end
         R_DATA: begin
            o_rvalid = 1'b1;
            if (i_rready && o_rlast) r_next = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

   // Read data is fetched on the accepting edge so the next beat is ready while rvalid stays high.
   always_ff @(posedge i_aclk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         r_state <= R_IDLE;
         rb      <= '0;
         r_cnt   <= '0;
         o_rid   <= '0;
         o_rdata <= '0;
         o_rresp <= RESP_OKAY;
         o_rlast <= 1'b0;
      end else begin
         r_state <= r_next;
         if (ar_fire || (r_fire && !o_rlast)) begin
            o_rdata <= rd_oor ? '0 : mem[rd_idx[MEM_AW-1:0]];
            o_rresp <= (rd_oor || rd_illegal) ? RESP_SLVERR : RESP_OKAY;
         end
         if (ar_fire) begin
            rb      <= ar_req;
            r_cnt   <= '0;
            o_rid   <= i_arid;
            o_rlast <= (i_arlen == 8'd0);
         end else if (r_fire && !o_rlast) begin
            rb.addr <= r_addr_nxt;
            r_cnt   <= r_cnt + 8'd1;
            o_rlast <= ((r_cnt + 8'd1) == rb.len);
         end
      end
   end

   // ---------------- write engine ----------------
   typedef enum logic [1:0] {W_ADDR, W_DATA, W_RESP} w_state_t;

   w_state_t         w_state, w_next;
   burst_t           wb, aw_req;
   logic [7:0]       w_cnt;
   logic             w_err, aw_fire, w_fire, w_last, w_oor, w_beat_err;
   logic [IDX_W-1:0] w_idx;

   assign aw_req     = '{addr: i_awaddr, len: i_awlen, burst: i_awburst};
   assign aw_fire    = o_awready & i_awvalid;
   assign w_fire     = o_wready & i_wvalid;
   assign w_idx      = wb.addr[ADDR_W-1:LSB];
   assign w_oor      = out_of_range(w_idx);
   assign w_last     = (w_cnt == wb.len);
   assign w_beat_err = w_oor | (i_wlast != w_last) | illegal_burst(wb.len, wb.burst);

   always_comb begin
      w_next    = w_state;
      o_awready = 1'b0;
      o_wready  = 1'b0;
      o_bvalid  = 1'b0;
      case (w_state)
         W_ADDR: begin
            o_awready = 1'b1;
            if (i_awvalid) w_next = W_DATA;
         end
         W_DATA: begin
            o_wready = 1'b1;
            if (i_wvalid && w_last) w_next = W_RESP;
         end
         W_RESP: begin
            o_bvalid = 1'b1;
            if (i_bready) w_next = W_ADDR;
         end
         default: w_next = W_ADDR;
      endcase
   end

   // The beat count alone ends the burst; a misplaced wlast only poisons the response.
   always_ff @(posedge i_aclk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         w_state <= W_ADDR;
         wb      <= '0;
         w_cnt   <= '0;
         w_err   <= 1'b0;
         o_bid   <= '0;
         o_bresp <= RESP_OKAY;
      end else begin
         w_state <= w_next;
         if (aw_fire) begin
            wb    <= aw_req;
            w_cnt <= '0;
            w_err <= 1'b0;
            o_bid <= i_awid;
         end else if (w_fire) begin
            if (w_last) begin
               o_bresp <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
               w_err   <= 1'b0;
            end else begin
               wb.addr <= next_addr(wb);
               w_cnt   <= w_cnt + 8'd1;
               w_err   <= w_err | w_beat_err;
            end
         end
      end
   end

   always_ff @(posedge i_aclk) begin
      if (w_fire && !w_oor) begin
         for (int i = 0; i < BYTES; i++) begin
            if (i_wstrb[i]) mem[w_idx[MEM_AW-1:0]][i*8 +: 8] <= i_wdata[i*8 +: 8];
         end
      end
   end

endmodule

// File: tb/tb_sram_axi_slave.sv
// Scoreboard bench for sram_axi_slave: a byte-level memory model predicts every R beat and B response.
module tb_sram_axi_slave;
   localparam int DEPTH = 256;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [3:0]  arid = '0, awid = '0;
   logic [15:0] araddr = '0, awaddr = '0;
   logic [7:0]  arlen = '0, awlen = '0;
   logic [1:0]  arburst = '0, awburst = '0;
   logic        arvalid = 1'b0, awvalid = 1'b0, rready = 1'b0, bready = 1'b0;
   logic [63:0] wdata = '0;
   logic [7:0]  wstrb = '0;
   logic        wlast = 1'b0, wvalid = 1'b0;
   logic        arready, rlast, rvalid, awready, wready, bvalid;
   logic [3:0]  rid, bid;
   logic [63:0] rdata;
   logic [1:0]  rresp, bresp;

   always #5 clk = ~clk;

   sram_axi_slave #(.DATA_W(64), .ADDR_W(16), .ID_W(4), .DEPTH(DEPTH)) dut (
      .i_aclk(clk), .i_areset_n(rst_n),
      .i_arid(arid), .i_araddr(araddr), .i_arlen(arlen), .i_arburst(arburst),
      .i_arvalid(arvalid), .o_arready(arready),
      .o_rid(rid), .o_rdata(rdata), .o_rresp(rresp), .o_rlast(rlast),
      .o_rvalid(rvalid), .i_rready(rready),
      .i_awid(awid), .i_awaddr(awaddr), .i_awlen(awlen), .i_awburst(awburst),
      .i_awvalid(awvalid), .o_awready(awready),
      .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast), .i_wvalid(wvalid), .o_wready(wready),
      .o_bid(bid), .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready)
   );

   typedef struct packed {
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [3:0]  id;
   } beat_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } bresp_t;

   beat_t       exp_r[$], got_r[$];
   bresp_t      exp_b[$], got_b[$];
   logic [63:0] model [DEPTH];
   int          n_tests = 0;
   int          n_fail  = 0;
   beat_t       e, g;
   bresp_t      eb, gb;

   function automatic logic m_illegal(input logic [7:0] len, input logic [1:0] burst);
      if (burst == 2'b11) return 1'b1;
      if (burst == 2'b10) return !(len == 1 || len == 3 || len == 7 || len == 15);
      return 1'b0;
   endfunction

   function automatic logic [15:0] m_next(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst);
      int container, base;
      if (burst == 2'b00) return addr;
      if (burst == 2'b10 && !m_illegal(len, burst)) begin
         container = 8 * (int'(len) + 1);
         base      = (int'(addr) / container) * container;
         return 16'(base + ((int'(addr) - base + 8) % container));
      end
      return addr + 16'd8;
   endfunction

   task automatic timeout_fail(input string what);
      n_tests++;
      n_fail++;
      $display("FAIL %s: handshake timed out, got no response, required one within 1000 cycles", what);
   endtask

   task automatic push_exp_read(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst);
      logic [15:0] a;
      beat_t       x;
      int          widx;
      a = addr;
      for (int b = 0; b <= int'(len); b++) begin
         widx   = int'(a) / 8;
         x.id   = id;
         x.last = (b == int'(len));
         if (widx >= DEPTH) begin
            x.data = '0;
            x.resp = 2'b10;
         end else begin
            x.data = model[widx];
            x.resp = m_illegal(len, burst) ? 2'b10 : 2'b00;
         end
         exp_r.push_back(x);
         a = m_next(a, len, burst);
      end
   endtask

   task automatic issue_ar(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst);
      int t = 0;
      arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
      while (!arready && t < 1000) begin @(posedge clk); #1; t++; end
      if (t >= 1000) timeout_fail("ar_handshake");
      @(posedge clk); #1;
      arvalid = 1'b0;
   endtask

   task automatic issue_aw(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst);
      int t = 0;
      awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
      while (!awready && t < 1000) begin @(posedge clk); #1; t++; end
      if (t >= 1000) timeout_fail("aw_handshake");
      @(posedge clk); #1;
      awvalid = 1'b0;
   endtask

   task automatic do_read(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst);
      int t = 0, n = 0;
      logic done = 1'b0;
      issue_ar(id, addr, len, burst);
      rready = 1'b1;
      while (!done && t < 1000) begin
         if (rvalid) begin
            got_r.push_back('{data: rdata, resp: rresp, last: rlast, id: rid});
            n++;
            if (rlast || n > 300) done = 1'b1;
         end
         @(posedge clk); #1;
         t++;
      end
      rready = 1'b0;
      if (!done) timeout_fail("r_beats");
   endtask

   // Drives one write burst and updates the model with what the slave is expected to store.
   task automatic do_write(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [63:0] base, input logic [7:0] strb, input int wlast_at);
      logic [15:0] a;
      logic [63:0] d;
      logic        err;
      int          widx, t;
      a   = addr;
      err = m_illegal(len, burst);
      issue_aw(id, addr, len, burst);
      for (int b = 0; b <= int'(len); b++) begin
         d = base * 64'(b + 1);
         wdata = d; wstrb = strb; wlast = (b == wlast_at); wvalid = 1'b1;
         t = 0;
         while (!wready && t < 1000) begin @(posedge clk); #1; t++; end
         if (t >= 1000) timeout_fail("w_beat");
         widx = int'(a) / 8;
         if (widx >= DEPTH) err = 1'b1;
         else for (int i = 0; i < 8; i++) if (strb[i]) model[widx][8*i +: 8] = d[8*i +: 8];
         if ((b == wlast_at) != (b == int'(len))) err = 1'b1;
         @(posedge clk); #1;
         a = m_next(a, len, burst);
      end
      wvalid = 1'b0;
      wlast  = 1'b0;
      exp_b.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
      bready = 1'b1;
      t = 0;
      while (!bvalid && t < 1000) begin @(posedge clk); #1; t++; end
      if (t >= 1000) timeout_fail("b_resp");
      else got_b.push_back('{id: bid, resp: bresp});
      @(posedge clk); #1;
      bready = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({arready, awready, wready, rvalid, rlast, bvalid} !== 6'b110000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b, required 110000", {arready, awready, wready, rvalid, rlast, bvalid});
      end
      n_tests++;
      if ({rdata, rresp, rid, bid, bresp} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got rdata=%h rresp=%b rid=%h bid=%h bresp=%b, required all 0", rdata, rresp, rid, bid, bresp);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_incr;
      do_write(4'd5, 16'h0010, 8'd3, 2'b01, 64'h1111_1111_1111_1111, 8'hFF, 3);
      n_tests++;
      if (got_b.size() == 0) begin n_fail++; $display("FAIL incr_b: got no B, required id=5 resp=00"); end
      else begin
         gb = got_b.pop_front(); eb = exp_b.pop_front();
         if (gb !== eb || gb !== 6'b0101_00) begin n_fail++; $display("FAIL incr_b: got id=%h resp=%b, required id=5 resp=00", gb.id, gb.resp); end
      end
      push_exp_read(4'd5, 16'h0010, 8'd3, 2'b01);
      do_read(4'd5, 16'h0010, 8'd3, 2'b01);
      while (exp_r.size() > 0) begin
         e = exp_r.pop_front();
         n_tests++;
         if (got_r.size() == 0) begin n_fail++; $display("FAIL incr_rd: got no beat, required data=%h", e.data); end
         else begin
            g = got_r.pop_front();
            if (g !== e) begin n_fail++; $display("FAIL incr_rd: got %h/%b/%b/%h, required %h/%b/%b/%h", g.data, g.resp, g.last, g.id, e.data, e.resp, e.last, e.id); end
         end
      end
   endtask

   task automatic test_strobe;
      do_write(4'd1, 16'h0030, 8'd0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
      do_write(4'd2, 16'h0030, 8'd0, 2'b01, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 0);
      while (exp_b.size() > 0) begin
         eb = exp_b.pop_front();
         n_tests++;
         if (got_b.size() == 0) begin n_fail++; $display("FAIL strb_b: got no B, required id=%h", eb.id); end
         else begin
            gb = got_b.pop_front();
            if (gb !== eb) begin n_fail++; $display("FAIL strb_b: got id=%h resp=%b, required id=%h resp=%b", gb.id, gb.resp, eb.id, eb.resp); end
         end
      end
      do_read(4'd2, 16'h0030, 8'd0, 2'b01);
      n_tests++;
      if (got_r.size() == 0) begin n_fail++; $display("FAIL strb_rd: got no beat, required ffffffffbbbbbbbb"); end
      else begin
         g = got_r.pop_front();
         if (g.data !== 64'hFFFF_FFFF_BBBB_BBBB || g.resp !== 2'b00 || g.last !== 1'b1) begin
            n_fail++; $display("FAIL strb_rd: got %h/%b/%b, required ffffffffbbbbbbbb/00/1", g.data, g.resp, g.last);
         end
      end
   endtask

   task automatic test_wrap_fixed;
      do_write(4'd3, 16'h0000, 8'd3, 2'b01, 64'h0101_0101_0101_0101, 8'hFF, 3);
      void'(exp_b.pop_front()); void'(got_b.pop_front());
      push_exp_read(4'd7, 16'h0018, 8'd3, 2'b10);
      do_read(4'd7, 16'h0018, 8'd3, 2'b10);
      push_exp_read(4'd8, 16'h0008, 8'd2, 2'b00);
      do_read(4'd8, 16'h0008, 8'd2, 2'b00);
      push_exp_read(4'd9, 16'h0000, 8'd2, 2'b10);
      do_read(4'd9, 16'h0000, 8'd2, 2'b10);
      n_tests++;
      if (exp_r.size() != 10 || exp_r[1].data !== 64'h0101_0101_0101_0101 || exp_r[4].data !== exp_r[6].data) begin
         n_fail++; $display("FAIL wrap_model: got %0d entries, required 10 with wrap to word 0", exp_r.size());
      end
      while (exp_r.size() > 0) begin
         e = exp_r.pop_front();
         n_tests++;
         if (got_r.size() == 0) begin n_fail++; $display("FAIL wrap_fixed_rd: got no beat, required data=%h", e.data); end
         else begin
            g = got_r.pop_front();
            if (g !== e) begin n_fail++; $display("FAIL wrap_fixed_rd: got %h/%b/%b/%h, required %h/%b/%b/%h", g.data, g.resp, g.last, g.id, e.data, e.resp, e.last, e.id); end
         end
      end
   endtask

   task automatic test_out_of_range;
      do_write(4'd1, 16'h07F8, 8'd0, 2'b01, 64'h5555_6666_7777_8888, 8'hFF, 0);
      do_write(4'd6, 16'h0800, 8'd0, 2'b01, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 0);
      while (exp_b.size() > 0) begin
         eb = exp_b.pop_front();
         n_tests++;
         if (got_b.size() == 0) begin n_fail++; $display("FAIL oor_b: got no B, required id=%h resp=%b", eb.id, eb.resp); end
         else begin
            gb = got_b.pop_front();
            if (gb !== eb) begin n_fail++; $display("FAIL oor_b: got id=%h resp=%b, required id=%h resp=%b", gb.id, gb.resp, eb.id, eb.resp); end
         end
      end
      push_exp_read(4'd2, 16'h07F8, 8'd1, 2'b01);
      do_read(4'd2, 16'h07F8, 8'd1, 2'b01);
      push_exp_read(4'd3, 16'h0800, 8'd0, 2'b01);
      do_read(4'd3, 16'h0800, 8'd0, 2'b01);
      push_exp_read(4'd4, 16'h0000, 8'd0, 2'b01);
      do_read(4'd4, 16'h0000, 8'd0, 2'b01);
      while (exp_r.size() > 0) begin
         e = exp_r.pop_front();
         n_tests++;
         if (got_r.size() == 0) begin n_fail++; $display("FAIL oor_rd: got no beat, required data=%h resp=%b", e.data, e.resp); end
         else begin
            g = got_r.pop_front();
            if (g !== e) begin n_fail++; $display("FAIL oor_rd: got %h/%b/%b/%h, required %h/%b/%b/%h", g.data, g.resp, g.last, g.id, e.data, e.resp, e.last, e.id); end
         end
      end
   endtask

   task automatic test_backpressure;
      int t;
      do_write(4'd1, 16'h0040, 8'd3, 2'b01, 64'h0F0F_1234_5678_9ABC, 8'hFF, 3);
      void'(exp_b.pop_front()); void'(got_b.pop_front());
      push_exp_read(4'd6, 16'h0040, 8'd3, 2'b01);
      issue_ar(4'd6, 16'h0040, 8'd3, 2'b01);
      for (int b = 0; b < 4; b++) begin
         t = 0;
         while (!rvalid && t < 1000) begin @(posedge clk); #1; t++; end
         if (t >= 1000) timeout_fail("bp_rvalid");
         e = exp_r.pop_front();
         if (b == 2) begin
            repeat (5) begin
               n_tests++;
               if ({rvalid, rdata, rlast, rresp} !== {1'b1, e.data, e.last, e.resp}) begin
                  n_fail++; $display("FAIL bp_hold: got v=%b %h/%b/%b, required v=1 %h/%b/%b", rvalid, rdata, rlast, rresp, e.data, e.last, e.resp);
               end
               @(posedge clk); #1;
            end
         end
         n_tests++;
         if ({rdata, rresp, rlast, rid} !== {e.data, e.resp, e.last, e.id}) begin
            n_fail++; $display("FAIL bp_beat: got %h/%b/%b/%h, required %h/%b/%b/%h", rdata, rresp, rlast, rid, e.data, e.resp, e.last, e.id);
         end
         rready = 1'b1;
         @(posedge clk); #1;
         rready = 1'b0;
      end
      n_tests++;
      if ({rvalid, arready} !== 2'b01) begin n_fail++; $display("FAIL bp_end: got rvalid/arready=%b, required 01", {rvalid, arready}); end
   endtask

   task automatic test_wlast_early;
      do_write(4'd9, 16'h0060, 8'd3, 2'b01, 64'h2468_ACE0_1357_9BDF, 8'hFF, 1);
      n_tests++;
      if (got_b.size() == 0) begin n_fail++; $display("FAIL wlast_b: got no B, required id=9 resp=10"); end
      else begin
         gb = got_b.pop_front(); eb = exp_b.pop_front();
         if (gb !== eb || gb.resp !== 2'b10) begin n_fail++; $display("FAIL wlast_b: got id=%h resp=%b, required id=9 resp=10", gb.id, gb.resp); end
      end
      push_exp_read(4'd9, 16'h0060, 8'd3, 2'b01);
      do_read(4'd9, 16'h0060, 8'd3, 2'b01);
      while (exp_r.size() > 0) begin
         e = exp_r.pop_front();
         n_tests++;
         if (got_r.size() == 0) begin n_fail++; $display("FAIL wlast_rd: got no beat, required data=%h", e.data); end
         else begin
            g = got_r.pop_front();
            if (g !== e) begin n_fail++; $display("FAIL wlast_rd: got %h/%b/%b/%h, required %h/%b/%b/%h", g.data, g.resp, g.last, g.id, e.data, e.resp, e.last, e.id); end
         end
      end
   endtask

   task automatic test_reset_mid;
      issue_ar(4'd2, 16'h0000, 8'd7, 2'b01);
      issue_aw(4'd3, 16'h0320, 8'd7, 2'b01);
      rready = 1'b1;
      wvalid = 1'b1; wdata = 64'hCAFE_CAFE_CAFE_CAFE; wstrb = 8'hFF; wlast = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({arready, awready, wready, rvalid, rlast, bvalid} !== 6'b110000 || {rdata, rresp, rid, bid, bresp} !== '0) begin
         n_fail++; $display("FAIL rst_mid: got ctrl=%b rdata=%h rid=%h bid=%h, required ctrl=110000 data/ids 0",
                            {arready, awready, wready, rvalid, rlast, bvalid}, rdata, rid, bid);
      end
      rready = 1'b0; wvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({arready, awready, wready, rvalid, bvalid} !== 5'b11000) begin
         n_fail++; $display("FAIL rst_release: got %b, required 11000", {arready, awready, wready, rvalid, bvalid});
      end
      do_write(4'd7, 16'h00A0, 8'd0, 2'b01, 64'h1234_5678_9ABC_DEF0, 8'hFF, 0);
      n_tests++;
      if (got_b.size() == 0) begin n_fail++; $display("FAIL rst_new_b: got no B, required id=7 resp=00"); end
      else begin
         gb = got_b.pop_front(); eb = exp_b.pop_front();
         if (gb !== eb) begin n_fail++; $display("FAIL rst_new_b: got id=%h resp=%b, required id=%h resp=%b", gb.id, gb.resp, eb.id, eb.resp); end
      end
      push_exp_read(4'd7, 16'h00A0, 8'd0, 2'b01);
      do_read(4'd7, 16'h00A0, 8'd0, 2'b01);
      e = exp_r.pop_front();
      n_tests++;
      if (got_r.size() == 0) begin n_fail++; $display("FAIL rst_new_rd: got no beat, required data=%h", e.data); end
      else begin
         g = got_r.pop_front();
         if (g !== e) begin n_fail++; $display("FAIL rst_new_rd: got %h/%b/%b/%h, required %h/%b/%b/%h", g.data, g.resp, g.last, g.id, e.data, e.resp, e.last, e.id); end
      end
   endtask

   initial begin
      test_reset();
      test_incr();
      test_strobe();
      test_wrap_fixed();
      test_out_of_range();
      test_backpressure();
      test_wlast_early();
      test_reset_mid();
      n_tests++;
      if (got_r.size() != 0 || got_b.size() != 0) begin
         n_fail++; $display("FAIL leftover: got %0d R and %0d B unmatched, required 0", got_r.size(), got_b.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_axi_slave.md
Name: sram_axi_slave

Overview:
- Parametrised AXI4 slave SRAM; successor to the fixed 64-bit/256-entry slave.
- Full, independent read and write engines: FIXED, INCR and WRAP bursts, byte strobes, ID echo, SLVERR on out-of-range access.
- Sits on the AXI4 interconnect as a scratch/boot memory target.
- Unused AXI sideband signals (lock/cache/prot/qos/region/user/size) are not carried.

Parameters:
- DATA_W, 64, beat width in bits (power of 2, ≥16); BYTES = DATA_W/8, LSB = log2(BYTES).
- ADDR_W, 16, byte-address width.
- ID_W, 4, transaction ID width.
- DEPTH, 256, number of DATA_W words.

Ports:
i_aclk  in  1  clock
i_areset_n  in  1  asynchronous active-low reset
i_arid  in  ID_W  read ID
i_araddr  in  ADDR_W  read start byte address
i_arlen  in  8  beats-1
i_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP
i_arvalid  in  1  AR valid
o_arready  out  1  AR ready
o_rid  out  ID_W  latched arid
o_rdata  out  DATA_W  read data
o_rresp  out  2  00 OKAY, 10 SLVERR
o_rlast  out  1  final beat
o_rvalid  out  1  R valid
i_rready  in  1  R ready
i_awid  in  ID_W  write ID
i_awaddr  in  ADDR_W  write start byte address
i_awlen  in  8  beats-1
i_awburst  in  2  burst type
i_awvalid  in  1  AW valid
o_awready  out  1  AW ready
i_wdata  in  DATA_W  write data
i_wstrb  in  BYTES  byte enables
i_wlast  in  1  master last flag
i_wvalid  in  1  W valid
o_wready  out  1  W ready
o_bid  out  ID_W  latched awid
o_bresp  out  2  write response
o_bvalid  out  1  B valid
i_bready  in  1  B ready

Behaviour:
- Reset (async, active-low): o_arready=1, o_awready=1; o_wready, o_rvalid, o_rlast, o_bvalid = 0; o_rdata, o_rresp, o_rid, o_bid, o_bresp = 0. Both FSMs to idle; beat counters to 0. Memory not cleared.
- Reset mid-burst aborts the burst and its response; no further beats are issued.
- Word index = addr[ADDR_W-1:LSB]. Index ≥ DEPTH is out of range.
- Next address:
  - FIXED: unchanged.
  - INCR: addr+BYTES, modulo 2^ADDR_W.
  - WRAP: container = BYTES*(len+1); next = (addr & ~(container-1)) | ((addr+BYTES) & (container-1)). Legal only for len ∈ {1,3,7,15}.
  - Illegal WRAP len or burst 11: treated as INCR, whole burst responds SLVERR.
- Read FSM:
  - R_IDLE (arready=1): AR handshake latches id/addr/len/burst, clears counter, goes to R_DATA.
  - R_DATA (arready=0): o_rvalid=1 the cycle after AR handshake; rdata is the registered read of the current address.
  - Each R handshake advances address and counter and loads the next word; rvalid stays high.
  - rlast=1 iff counter==len. rresp=SLVERR for an out-of-range beat (rdata=0) or an illegal burst.
  - Handshake with rlast=1: rvalid=0, return to R_IDLE, arready=1 the next cycle.
  - rdata/rlast/rresp hold while rvalid=1 and rready=0.
- Write FSM:
  - W_ADDR (awready=1): AW handshake latches id/addr/len/burst, goes to W_DATA.
  - W_DATA (awready=0, wready=1): each W handshake writes bytes with wstrb[i]=1. Out-of-range beats are dropped and flag SLVERR. i_wlast != (counter==len) flags SLVERR.
  - The burst ends on beat counter==len regardless of wlast, then goes to W_RESP.
  - W_RESP (wready=0, bvalid=1): bresp=SLVERR if any flag set, else OKAY. B handshake returns to W_ADDR, clears flags, awready=1 the next cycle.
- Read and write engines are fully concurrent. A read and a write to the same word in the same cycle: the read returns old data.
- Max burst 256 beats; 8-bit counters do not wrap within a burst.

Test Plan:
- Reset released; AW=0x0010 len=3 INCR id=5, wdata 0x11..,0x22..,0x33..,0x44.., wstrb=0xFF, wlast on beat 3 -> bvalid, bid=5, bresp=00; AR=0x0010 len=3 INCR -> 4 beats in order, rlast only on beat 3, rid echoed.
- Write wstrb=0x0F data 0xAAAAAAAA_BBBBBBBB over word 0xFFFFFFFF_FFFFFFFF -> readback 0xFFFFFFFF_BBBBBBBB.
- WRAP read addr=0x0018 len=3 (BYTES=8) -> beat addresses 0x18, 0x00, 0x08, 0x10.
- FIXED read len=2 at 0x0008 -> same word returned 3 times. AR to word index 256 -> rresp=10, rdata=0. AW out of range -> memory unchanged, bresp=10.
- rready low for 5 cycles mid-burst -> rdata stable, no beat lost. wlast early on beat 1 of len=3 -> burst still takes 4 beats, bresp=10.
- Assert i_areset_n=0 mid read burst and mid write burst -> outputs at reset values immediately; a new transaction then completes normally.
